// File: rtl/iterative_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_divider_pkg: op encodings and FSM states shared by the divider,  |
// | hazard unit and decoder.                                     Rev 1.0       |
// +----------------------------------------------------------------------------+
package iterative_divider_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iterative_divider_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_step: one restoring-division trial subtract (N+1-bit partial minus     |
// | zero-extended divisor), returning the low N bits and the borrow.  Rev 1.0  |
// +----------------------------------------------------------------------------+
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   partial_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] diff_o,
  output logic         neg_o
);

  logic [N:0] full;

  // partial < 2*divisor always holds, so bit N alone tells the sign.
  assign full   = partial_i - {1'b0, divisor_i};
  assign diff_o = full[N-1:0];
  assign neg_o  = full[N];

endmodule
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iterative_divider: multi-cycle radix-2 restoring divider for RV32M         |
// | DIV/DIVU/REM/REMU. Optional macro DIV_EARLY_EXIT_EN enables the early exit.|
// |                                                              Rev 1.0       |
// +----------------------------------------------------------------------------+
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  res_q, res_d;
  logic          is_rem_q, is_rem_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          div0_q, div0_d;
  logic          ovf_q, ovf_d;

  logic          sgn, a_neg, b_neg, b_zero, ovf_in;
  logic [N-1:0]  abs_a, abs_b;
  logic [N:0]    partial;
  logic [N-1:0]  diff;
  logic          step_neg;
  logic [N-1:0]  q_fix, r_fix;

  assign sgn    = op_is_signed(op);
  assign a_neg  = sgn & operand_a[N-1];
  assign b_neg  = sgn & operand_b[N-1];
  assign abs_a  = a_neg ? -operand_a : operand_a;
  assign abs_b  = b_neg ? -operand_b : operand_b;
  assign b_zero = (operand_b == '0);
  assign ovf_in = sgn & (operand_a == MIN_NEG) & (operand_b == '1);

  assign partial = {rem_q, quo_q[N-1]};

  div_step #(.N(N)) u_step (
    .partial_i (partial),
    .divisor_i (dvs_q),
    .diff_o    (diff),
    .neg_o     (step_neg)
  );

  // With b=0 the unsigned loop already leaves rem=|a|, so re-signing it yields a.
  assign q_fix = div0_q ? '1 : (ovf_q ? MIN_NEG : (neg_quo_q ? -quo_q : quo_q));
  assign r_fix = ovf_q ? '0 : (neg_rem_q ? -rem_q : rem_q);

`ifdef DIV_EARLY_EXIT_EN
  logic         early_exit;
  logic [N-1:0] early_res;

  assign early_exit = b_zero | ovf_in | (operand_a == '0);

  always_comb begin
    early_res = '0;
    if (b_zero) begin
      early_res = op_is_rem(op) ? operand_a : '1;
    end else if (ovf_in) begin
      early_res = op_is_rem(op) ? '0 : MIN_NEG;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          cnt_d     = CNT_LOAD;
          rem_d     = '0;
          quo_d     = abs_a;
          dvs_d     = abs_b;
          is_rem_d  = op_is_rem(op);
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = b_zero;
          ovf_d     = ovf_in;
          state_d   = S_CALC;
`ifdef DIV_EARLY_EXIT_EN
          if (early_exit) begin
            res_d   = early_res;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_neg ? partial[N-1:0] : diff;
          quo_d = {quo_q[N-2:0], ~step_neg};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        busy = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          res_d   = is_rem_q ? r_fix : q_fix;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = ~flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result = res_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_iterative_divider: scoreboard bench for iterative_divider (N=32).       |
// |                                                              Rev 1.0       |
// +----------------------------------------------------------------------------+
module tb_iterative_divider;

  localparam int          N      = 32;
  localparam int          LAT    = N + 2;
  localparam logic [N-1:0] MINNEG = 32'h8000_0000;

  typedef struct packed {
    logic [1:0]   o;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] result;
  logic         busy;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_exp = '0;

  always #5 clk = ~clk;

  iterative_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .result    (result),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    logic signed [N-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == '0) return o[1] ? x : '1;
    if (!o[0]) begin
      if (x == MINNEG && y == '1) return o[1] ? '0 : MINNEG;
      return o[1] ? N'(sx % sy) : N'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef DIV_EARLY_EXIT_EN
    if (y == '0 || x == '0 || (!o[0] && x == MINNEG && y == '1)) return 1;
`endif
    return LAT;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input bit push);
    @(negedge clk);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) exp_q.push_back(model(o, x, y));
  endtask

  task automatic wait_done(output int cyc, output logic got, output logic busy1);
    cyc   = 0;
    got   = 1'b0;
    busy1 = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      got = done;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h busy=%b done=%b, required 0/0/0", result, busy, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t         tbl [13];
    int           cyc;
    logic         got, b1;
    logic [N-1:0] expv;
    tbl = '{
      '{2'b01, 32'd100,        32'd7},
      '{2'b11, 32'd100,        32'd7},
      '{2'b00, 32'hFFFF_FFF9,  32'd2},
      '{2'b10, 32'hFFFF_FFF9,  32'd2},
      '{2'b10, 32'd7,          32'hFFFF_FFFE},
      '{2'b00, 32'd5,          32'd0},
      '{2'b10, 32'hFFFF_FFFB,  32'd0},
      '{2'b01, 32'hFFFF_FFFF,  32'd0},
      '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF},
      '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF},
      '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF},
      '{2'b11, 32'd0,          32'd5},
      '{2'b00, 32'd0,          32'd0}
    };
    foreach (tbl[i]) begin
      issue(tbl[i].o, tbl[i].a, tbl[i].b, 1'b1);
      wait_done(cyc, got, b1);
      expv     = exp_q.pop_front();
      last_exp = expv;
      checks++;
      if (!got || result !== expv) begin
        errors++;
        $display("FAIL vec%0d result: got %h done=%b, required %h", i, result, got, expv);
      end
      checks++;
      if (cyc != exp_lat(tbl[i].o, tbl[i].a, tbl[i].b)) begin
        errors++;
        $display("FAIL vec%0d latency: got %0d, required %0d", i, cyc, exp_lat(tbl[i].o, tbl[i].a, tbl[i].b));
      end
      if (exp_lat(tbl[i].o, tbl[i].a, tbl[i].b) > 1) begin
        checks++;
        if (b1 !== 1'b1) begin
          errors++;
          $display("FAIL vec%0d busy after start: got %b, required 1", i, b1);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_random();
    int           cyc;
    logic         got, b1;
    logic [1:0]   o;
    logic [N-1:0] x, y, expv;
    for (int k = 0; k < 10; k++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      y = ($urandom_range(0, 2) == 0) ? N'($urandom_range(1, 20)) : $urandom();
      if (k == 3) x = -x;
      issue(o, x, y, 1'b1);
      wait_done(cyc, got, b1);
      expv     = exp_q.pop_front();
      last_exp = expv;
      checks++;
      if (!got || result !== expv) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got %h, required %h", k, o, x, y, result, expv);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_busy_start();
    int           cyc;
    logic         got;
    logic [N-1:0] expv;
    issue(2'b01, 32'd1000, 32'd7, 1'b1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == 5);
      if (cyc == 5) begin
        op = 2'b00;
        a  = 32'd5;
        b  = 32'd1;
      end
      got = done;
    end
    expv     = exp_q.pop_front();
    last_exp = expv;
    checks++;
    if (!got || result !== expv || cyc != LAT) begin
      errors++;
      $display("FAIL busy_start: result %h at cycle %0d, required %h at %0d", result, cyc, expv, LAT);
    end
    @(posedge clk);
  endtask

  task automatic test_flush();
    int   cyc;
    logic seen;
    issue(2'b01, 32'd500, 32'd3, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) seen = 1'b1;
      if (cyc == 10) flush = 1'b1;
      if (cyc == 11) begin
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL flush busy: got %b, required 0", busy);
        end
      end
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush done: got done pulse, required none");
    end
    checks++;
    if (result !== last_exp) begin
      errors++;
      $display("FAIL flush result: got %h, required %h", result, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    int           cyc;
    logic         got, b1;
    logic [N-1:0] expv;
    issue(2'b01, 32'h0000_FFFF, 32'd3, 1'b0);
    cyc = 0;
    while (cyc < 12) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, required 0/0/0", busy, done, result);
    end
    last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b01, 32'd9, 32'd3, 1'b1);
    wait_done(cyc, got, b1);
    expv     = exp_q.pop_front();
    last_exp = expv;
    checks++;
    if (!got || result !== expv) begin
      errors++;
      $display("FAIL after_reset divu: got %h, required %h", result, expv);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int           cyc, first;
    logic         got2;
    logic [N-1:0] expv;
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    cyc   = 0;
    first = 0;
    got2  = 1'b0;
    while (!got2 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done && first == 0) begin
        first = cyc;
        expv  = exp_q.pop_front();
        checks++;
        if (result !== expv || cyc != LAT) begin
          errors++;
          $display("FAIL b2b first: result %h at cycle %0d, required %h at %0d", result, cyc, expv, LAT);
        end
        op = 2'b00;
        a  = 32'hFFFF_FF9C;
        b  = 32'd7;
        exp_q.push_back(model(op, a, b));
      end else if (done) begin
        got2 = 1'b1;
      end
      if (first != 0 && cyc == first + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b start in done: busy got %b, required 0", busy);
        end
      end
      if (first != 0 && cyc == first + 2) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b restart busy: got %b, required 1", busy);
        end
      end
    end
    start = 1'b0;
    expv  = exp_q.pop_front();
    checks++;
    if (!got2 || result !== expv || cyc != first + N + 3) begin
      errors++;
      $display("FAIL b2b second: result %h at cycle %0d, required %h at %0d", result, cyc, expv, first + N + 3);
    end
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_busy_start();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
